// File: rtl/aes_csr_pkg.sv
// Shared types and address helpers for the AES register bank.
package aes_csr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_DONE   = 0;
    localparam int STAT_BUSY   = 1;

    function automatic int msg_base(input int n_key);
        return n_key;
    endfunction

    function automatic int res_base(input int n_key, input int n_msg);
        return n_key + n_msg;
    endfunction

endpackage

// File: rtl/aes_csr_word.sv
// One bank word: byte-lane software write, protect gate, core load.
module aes_csr_word #(
    parameter int DATA_W = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                wr_en,
    input  logic                wr_protect,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                ld_en,
    input  logic [DATA_W-1:0]   ld_data,
    output logic [DATA_W-1:0]   q
);

    logic [DATA_W-1:0] wmask;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < DATA_W/8; i++) begin
            wmask[8*i +: 8] = {8{byte_en[i]}};
        end
    end

    // Core loads win over software; only RES words ever see both.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            q <= '0;
        end else if (ld_en) begin
            q <= ld_data;
        end else if (wr_en && !wr_protect) begin
            q <= (q & ~wmask) | (wdata & wmask);
        end
    end

endmodule

// File: rtl/aes_csr_bank.sv
// Avalon-MM CSR bank and start/done handshake for the AES core.
// Define AES_CSR_IRQ_EN to add the IRQ output and CTRL.IRQ_ENABLE.
module aes_csr_bank
    import aes_csr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int N_KEY  = 4,
    parameter int N_MSG  = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    AVL_CS,
    input  logic                    AVL_READ,
    input  logic                    AVL_WRITE,
    input  logic [DATA_W/8-1:0]     AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]       AVL_ADDR,
    input  logic [DATA_W-1:0]       AVL_WRITEDATA,
    output logic [DATA_W-1:0]       AVL_READDATA,
    output logic                    CORE_START,
    output logic [N_KEY*DATA_W-1:0] CORE_KEY,
    output logic [N_MSG*DATA_W-1:0] CORE_MSG_IN,
    input  logic [N_MSG*DATA_W-1:0] CORE_MSG_OUT,
    input  logic                    CORE_DONE,
    output logic [31:0]             EXPORT_DATA
`ifdef AES_CSR_IRQ_EN
    ,
    output logic                    IRQ
`endif
);

    localparam int DEPTH    = 2**ADDR_W;
    localparam int N_REG    = N_KEY + 2*N_MSG;
    localparam int MSG_BASE = msg_base(N_KEY);
    localparam int RES_BASE = res_base(N_KEY, N_MSG);
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(DEPTH-2);
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(DEPTH-1);

    if (N_REG > DEPTH-2) begin : g_bad_map
        $error("aes_csr_bank: register map exceeds address space");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("aes_csr_bank: DATA_W must be a multiple of 8");
    end

    state_t            state_q;
    state_t            state_d;
    logic              start_d;
    logic              wr;
    logic              rd;
    logic              ctrl_wr;
    logic              res_ld;
    logic              irq_en;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] regs [N_REG];

    assign wr      = AVL_CS & AVL_WRITE;
    assign rd      = AVL_CS & AVL_READ;
    assign ctrl_wr = wr && AVL_ADDR == CTRL_ADDR && AVL_BYTE_EN[0];
    assign res_ld  = state_q == RUN && CORE_DONE;

    for (genvar g = 0; g < N_REG; g++) begin : g_reg
        localparam bit IS_RES = g >= RES_BASE;
        localparam int RI     = IS_RES ? g - RES_BASE : 0;
        aes_csr_word #(.DATA_W(DATA_W)) u_word (
            .CLK        (CLK),
            .RESET      (RESET),
            .wr_en      (wr && AVL_ADDR == ADDR_W'(g)),
            .wr_protect (IS_RES || state_q != IDLE),
            .byte_en    (AVL_BYTE_EN),
            .wdata      (AVL_WRITEDATA),
            .ld_en      (IS_RES && res_ld),
            .ld_data    (CORE_MSG_OUT[RI*DATA_W +: DATA_W]),
            .q          (regs[g])
        );
    end

    for (genvar k = 0; k < N_KEY; k++) begin : g_key
        assign CORE_KEY[k*DATA_W +: DATA_W] = regs[k];
    end
    for (genvar m = 0; m < N_MSG; m++) begin : g_msg
        assign CORE_MSG_IN[m*DATA_W +: DATA_W] = regs[MSG_BASE+m];
    end

    assign EXPORT_DATA = {CORE_KEY[N_KEY*DATA_W-1 -: 16],
                          CORE_KEY[15:0]};

    // START has no storage of its own: it reads 1 exactly when not IDLE.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        unique case (state_q)
            IDLE: if (ctrl_wr && AVL_WRITEDATA[CTRL_START]) begin
                state_d = RUN;
                start_d = 1'b1;
            end
            RUN: if (CORE_DONE) state_d = DONE;
            DONE: if (ctrl_wr && !AVL_WRITEDATA[CTRL_START]) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        unique case (1'b1)
            AVL_ADDR == CTRL_ADDR: begin
                rd_word[CTRL_START]  = state_q != IDLE;
                rd_word[CTRL_IRQ_EN] = irq_en;
            end
            AVL_ADDR == STAT_ADDR: begin
                rd_word[STAT_DONE] = state_q == DONE;
                rd_word[STAT_BUSY] = state_q == RUN;
            end
            default: begin
                for (int i = 0; i < N_REG; i++) begin
                    if (AVL_ADDR == ADDR_W'(i)) rd_word = regs[i];
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            CORE_START   <= 1'b0;
            AVL_READDATA <= '0;
        end else begin
            state_q    <= state_d;
            CORE_START <= start_d;
            if (rd) AVL_READDATA <= rd_word;
        end
    end

`ifdef AES_CSR_IRQ_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            irq_en <= 1'b0;
            IRQ    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= AVL_WRITEDATA[CTRL_IRQ_EN];
            IRQ <= state_q == DONE && irq_en;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_aes_csr_bank.sv
// Randomised scoreboard bench for aes_csr_bank against a map-level model.
module tb_aes_csr_bank;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         AVL_CS = 1'b0;
    logic         AVL_READ = 1'b0;
    logic         AVL_WRITE = 1'b0;
    logic [3:0]   AVL_BYTE_EN = '0;
    logic [3:0]   AVL_ADDR = '0;
    logic [31:0]  AVL_WRITEDATA = '0;
    logic [31:0]  AVL_READDATA;
    logic         CORE_START;
    logic [127:0] CORE_KEY;
    logic [127:0] CORE_MSG_IN;
    logic [127:0] CORE_MSG_OUT = '0;
    logic         CORE_DONE = 1'b0;
    logic [31:0]  EXPORT_DATA;
`ifdef AES_CSR_IRQ_EN
    logic         IRQ;
`endif

    aes_csr_bank dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .AVL_CS        (AVL_CS),
        .AVL_READ      (AVL_READ),
        .AVL_WRITE     (AVL_WRITE),
        .AVL_BYTE_EN   (AVL_BYTE_EN),
        .AVL_ADDR      (AVL_ADDR),
        .AVL_WRITEDATA (AVL_WRITEDATA),
        .AVL_READDATA  (AVL_READDATA),
        .CORE_START    (CORE_START),
        .CORE_KEY      (CORE_KEY),
        .CORE_MSG_IN   (CORE_MSG_IN),
        .CORE_MSG_OUT  (CORE_MSG_OUT),
        .CORE_DONE     (CORE_DONE),
        .EXPORT_DATA   (EXPORT_DATA)
`ifdef AES_CSR_IRQ_EN
        ,
        .IRQ           (IRQ)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Model: words 0-3 KEY, 4-7 MSG, 8-11 RES; phase 0 idle, 1 run, 2 done.
    logic [31:0] mem [12];
    int          m_phase;
    bit          m_irqen;
    bit          m_irq;
    bit          m_start;
    logic [31:0] exp_q [$];

    task automatic check(input string name,
                         input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] v;
        v = '0;
        if (a < 12) v = mem[a];
        else if (a == 14) v = {30'd0, m_irqen, m_phase != 0};
        else if (a == 15) v = {30'd0, m_phase == 1, m_phase == 2};
        return v;
    endfunction

    function automatic logic [127:0] model_block(input int base);
        return {mem[base+3], mem[base+2], mem[base+1], mem[base]};
    endfunction

    // Scoreboard monitor: a read accepted at one edge is compared at
    // the following falling edge; otherwise the read data must hold.
    bit          rd_seen = 0;
    bit          rst_seen = 0;
    bit          armed = 0;
    logic [31:0] last_rd = '0;

    always @(posedge CLK) begin
        rd_seen  <= AVL_CS && AVL_READ && !RESET;
        rst_seen <= RESET;
    end

    always @(negedge CLK) begin
        if (rst_seen) begin
            armed   = 1;
            last_rd = '0;
            check("rdata_reset", AVL_READDATA, 32'h0);
        end else if (rd_seen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rdata_unexpected: got %h", AVL_READDATA);
            end else begin
                last_rd = exp_q.pop_front();
                check("rdata", AVL_READDATA, last_rd);
            end
        end else if (armed) begin
            check("rdata_hold", AVL_READDATA, last_rd);
        end
    end

    task automatic check_outputs();
        check("core_start", CORE_START, m_start);
        check("core_key", CORE_KEY, model_block(0));
        check("core_msg_in", CORE_MSG_IN, model_block(4));
        check("export", EXPORT_DATA,
              {mem[3][31:16], mem[0][15:0]});
`ifdef AES_CSR_IRQ_EN
        check("irq", IRQ, m_irq);
`endif
    endtask

    task automatic op(input bit cs, input bit rd, input bit wr,
                      input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit dn,
                      input logic [127:0] mo);
        bit irq_n;
        bit pulse;
        int nph;
        irq_n = m_phase == 2 && m_irqen;
        pulse = 0;
        nph   = m_phase;
        if (cs && rd) exp_q.push_back(model_read(a));
        if (cs && wr) begin
            if (a < 8 && m_phase == 0) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem[a][8*i +: 8] = d[8*i +: 8];
            end
            if (a == 14 && be[0]) begin
                if (m_phase == 0 && d[0]) begin
                    nph   = 1;
                    pulse = 1;
                end
                if (m_phase == 2 && !d[0]) nph = 0;
`ifdef AES_CSR_IRQ_EN
                m_irqen = d[1];
`endif
            end
        end
        if (dn && m_phase == 1) begin
            for (int i = 0; i < 4; i++) mem[8+i] = mo[32*i +: 32];
            nph = 2;
        end
        m_phase       = nph;
        AVL_CS        = cs;
        AVL_READ      = rd;
        AVL_WRITE     = wr;
        AVL_ADDR      = a;
        AVL_WRITEDATA = d;
        AVL_BYTE_EN   = be;
        CORE_DONE     = dn;
        CORE_MSG_OUT  = mo;
        @(posedge CLK);
        #1;
        m_start   = pulse;
        m_irq     = irq_n;
        AVL_CS    = 0;
        AVL_READ  = 0;
        AVL_WRITE = 0;
        CORE_DONE = 0;
        check_outputs();
    endtask

    task automatic wr_(input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        op(1, 0, 1, a, d, be, 0, '0);
    endtask

    task automatic rd_(input logic [3:0] a);
        op(1, 1, 0, a, '0, '0, 0, '0);
    endtask

    task automatic done_(input logic [127:0] mo);
        op(0, 0, 0, '0, '0, '0, 1, mo);
    endtask

    task automatic idle_();
        op(0, 0, 0, '0, '0, '0, 0, '0);
    endtask

    // A core completion is driven during reset and must be discarded.
    task automatic do_reset();
        RESET        = 1;
        CORE_DONE    = 1;
        CORE_MSG_OUT = {$urandom, $urandom, $urandom, $urandom};
        @(posedge CLK);
        #1;
        RESET     = 0;
        CORE_DONE = 0;
        foreach (mem[i]) mem[i] = '0;
        m_phase = 0;
        m_irqen = 0;
        m_irq   = 0;
        m_start = 0;
        check_outputs();
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   a;
        logic [127:0] res;
        res = {32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
        @(posedge CLK);
        #1;
        do_reset();
        for (int i = 0; i < 16; i++) rd_(4'(i));

        wr_(0, 32'h1122_3344, 4'b0101);
        rd_(0);

        for (int i = 0; i < 8; i++) wr_(4'(i), $urandom, 4'hF);
        wr_(14, 32'h1, 4'h1);
        rd_(15);
        wr_(0, 32'hFFFF_FFFF, 4'hF);
        wr_(4, 32'h1, 4'hF);
        wr_(14, 32'h0, 4'h1);
        rd_(0);
        rd_(4);
        rd_(14);
        done_(res);
        for (int i = 8; i < 12; i++) rd_(4'(i));
        rd_(15);
        done_(rand128());
        rd_(8);
        wr_(14, 32'h0, 4'h1);
        rd_(15);
        wr_(9, 32'h5555_5555, 4'hF);
        rd_(9);
        op(1, 1, 1, 2, 32'hA5A5_A5A5, 4'hF, 0, '0);
        rd_(2);

        wr_(14, 32'h1, 4'h1);
        idle_();
        do_reset();
        done_(rand128());
        rd_(15);
        rd_(8);
        rd_(14);

`ifdef AES_CSR_IRQ_EN
        wr_(14, 32'h3, 4'h1);
        done_(rand128());
        idle_();
        wr_(14, 32'h1, 4'h1);
        idle_();
        rd_(14);
        wr_(14, 32'h0, 4'h1);
`endif

        for (int n = 0; n < 600; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 4'd14
                                             : 4'($urandom_range(0, 15));
            op($urandom_range(0, 9) != 0,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1,
               a, $urandom, 4'($urandom),
               $urandom_range(0, 3) == 0, rand128());
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        idle_();
        idle_();
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
